if_id_pipe_reg: RTL and testbench

IF/ID pipeline register sitting directly downstream of the fetch stage. It latches PC, NPC, instruction and valid from fetch, and feeds the decode stage.
Detects load-use hazards against the instruction in ID/EX and drives d_hazard_detected back to fetch, which stalls the PC.
Squashes wrong-path instructions after a taken branch, for a programmable number of fetch cycles.

---
 rtl/if_id_pipe_reg.sv | 98 +++++++++
 tb/tb_if_id_pipe_reg.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with load-use hazard detection and wrong-path squash after a taken branch.
// Latency: one cycle from fetch to if_id_*; d_hazard_detected is combinational from the ID/EX inputs.
// Backpressure: a load-use hazard holds every register; a taken branch overrides it. Optional IF_ID_PERF_CNT_EN adds stall/flush counters.
module if_id_pipe_reg #(
    parameter int unsigned  FLUSH_CYCLES = 1,
    parameter logic [31:0]  NOP_INST     = 32'h47FF041F,
    parameter int unsigned  RA_LSB       = 21,
    parameter int unsigned  RB_LSB       = 16,
    parameter int unsigned  ZERO_REG     = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_PC_out,
    input  logic [31:0] if_NPC_out,
    input  logic [31:0] if_IR_out,
    input  logic        if_valid_inst_out,
    input  logic        ex_take_branch_out,
    input  logic        id_ex_valid_inst,
    input  logic        id_ex_rd_mem,
    input  logic [4:0]  id_ex_dest_reg_idx,
    output logic [31:0] if_id_PC,
    output logic [31:0] if_id_NPC,
    output logic [31:0] if_id_IR,
    output logic        if_id_valid_inst,
    output logic        d_hazard_detected
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [2:0] SQ_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [4:0] ZERO_IDX  = 5'(ZERO_REG);

    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
            $fatal(1, "if_id_pipe_reg: FLUSH_CYCLES must be in 1..7");
        end
    endgenerate

    logic [2:0] sq_cnt;
    logic [4:0] ra_idx;
    logic [4:0] rb_idx;
    logic       raw_hazard;

    assign ra_idx = if_id_IR[RA_LSB +: 5];
    assign rb_idx = if_id_IR[RB_LSB +: 5];

    // Field B is compared even for literal-form instructions: a rare extra stall is cheaper than decoding here.
    assign raw_hazard = if_id_valid_inst & id_ex_valid_inst & id_ex_rd_mem
                      & (id_ex_dest_reg_idx != ZERO_IDX)
                      & ((id_ex_dest_reg_idx == ra_idx) | (id_ex_dest_reg_idx == rb_idx));

    assign d_hazard_detected = raw_hazard & ~ex_take_branch_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_PC         <= '0;
            if_id_NPC        <= '0;
            if_id_IR         <= NOP_INST;
            if_id_valid_inst <= 1'b0;
            sq_cnt           <= '0;
        end else if (ex_take_branch_out) begin
            if_id_PC         <= if_PC_out;
            if_id_NPC        <= if_NPC_out;
            if_id_IR         <= NOP_INST;
            if_id_valid_inst <= 1'b0;
            sq_cnt           <= SQ_RELOAD;
        end else if (!d_hazard_detected) begin
            if_id_PC  <= if_PC_out;
            if_id_NPC <= if_NPC_out;
            if (sq_cnt != 3'd0) begin
                if_id_IR         <= NOP_INST;
                if_id_valid_inst <= 1'b0;
                sq_cnt           <= sq_cnt - 3'd1;
            end else begin
                if_id_IR         <= if_IR_out;
                if_id_valid_inst <= if_valid_inst_out;
            end
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (d_hazard_detected && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (ex_take_branch_out && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed table-driven bench for if_id_pipe_reg; dut_a uses FLUSH_CYCLES=2, dut_b uses FLUSH_CYCLES=3.
module tb_if_id_pipe_reg;

    localparam logic [31:0] NOP  = 32'h47FF041F;
    localparam logic [31:0] IR_0 = 32'h12345678;
    localparam logic [31:0] IR_A = 32'h00641234;
    localparam logic [31:0] IR_Z = 32'h03E00005;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = '0, npc_in = '0, ir_in = '0;
    logic        v_in = 1'b0, br_in = 1'b0, ev_in = 1'b0, ld_in = 1'b0;
    logic [4:0]  dst_in = '0;

    logic [31:0] a_pc, a_npc, a_ir, b_pc, b_npc, b_ir;
    logic        a_v, a_haz, b_v, b_haz;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] a_stall, a_flush, b_stall, b_flush;
`endif

    logic        sel_b = 1'b0;
    logic [31:0] m_pc, m_npc, m_ir;
    logic        m_v, m_haz;
    assign m_pc  = sel_b ? b_pc  : a_pc;
    assign m_npc = sel_b ? b_npc : a_npc;
    assign m_ir  = sel_b ? b_ir  : a_ir;
    assign m_v   = sel_b ? b_v   : a_v;
    assign m_haz = sel_b ? b_haz : a_haz;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_id_pipe_reg #(.FLUSH_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .if_PC_out(pc_in), .if_NPC_out(npc_in), .if_IR_out(ir_in),
        .if_valid_inst_out(v_in), .ex_take_branch_out(br_in), .id_ex_valid_inst(ev_in),
        .id_ex_rd_mem(ld_in), .id_ex_dest_reg_idx(dst_in),
        .if_id_PC(a_pc), .if_id_NPC(a_npc), .if_id_IR(a_ir), .if_id_valid_inst(a_v),
        .d_hazard_detected(a_haz)
`ifdef IF_ID_PERF_CNT_EN
        , .stall_cnt(a_stall), .flush_cnt(a_flush)
`endif
    );

    if_id_pipe_reg #(.FLUSH_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .if_PC_out(pc_in), .if_NPC_out(npc_in), .if_IR_out(ir_in),
        .if_valid_inst_out(v_in), .ex_take_branch_out(br_in), .id_ex_valid_inst(ev_in),
        .id_ex_rd_mem(ld_in), .id_ex_dest_reg_idx(dst_in),
        .if_id_PC(b_pc), .if_id_NPC(b_npc), .if_id_IR(b_ir), .if_id_valid_inst(b_v),
        .d_hazard_detected(b_haz)
`ifdef IF_ID_PERF_CNT_EN
        , .stall_cnt(b_stall), .flush_cnt(b_flush)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        v, br, ev, ld;
        logic [4:0]  dst;
        logic        e_haz, e_v;
        logic [31:0] e_ir, e_pc;
    } vec_t;

    vec_t tbl[17];
    vec_t seq5[8];

    function automatic vec_t mk(logic [31:0] pc, logic [31:0] ir, logic v, logic br, logic ev,
                                logic ld, logic [4:0] dst, logic e_haz, logic e_v,
                                logic [31:0] e_ir, logic [31:0] e_pc);
        vec_t t;
        t.pc = pc; t.ir = ir; t.v = v; t.br = br; t.ev = ev; t.ld = ld; t.dst = dst;
        t.e_haz = e_haz; t.e_v = e_v; t.e_ir = e_ir; t.e_pc = e_pc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check the hazard before the edge and the registers after it.
    task automatic apply(input vec_t t, input string tag);
        pc_in = t.pc; npc_in = t.pc + 32'd4; ir_in = t.ir; v_in = t.v;
        br_in = t.br; ev_in = t.ev; ld_in = t.ld; dst_in = t.dst;
        @(negedge clk);
        chk({tag, " haz"}, 32'(m_haz), 32'(t.e_haz));
        @(posedge clk);
        #1;
        chk({tag, " valid"}, 32'(m_v), 32'(t.e_v));
        chk({tag, " ir"}, m_ir, t.e_ir);
        chk({tag, " pc"}, m_pc, t.e_pc);
        chk({tag, " npc"}, m_npc, t.e_pc + 32'd4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            pc     ir            v  br ev ld dst  haz e_v e_ir          e_pc
        tbl[0]  = mk(32'h10, IR_0,         1, 0, 0, 0, 0,   0,  1,  IR_0,         32'h10);
        tbl[1]  = mk(32'h14, IR_A,         1, 0, 1, 1, 17,  1,  1,  IR_0,         32'h10);
        tbl[2]  = mk(32'h14, IR_A,         1, 0, 0, 1, 17,  0,  1,  IR_A,         32'h14);
        tbl[3]  = mk(32'h18, 32'h0,        1, 0, 1, 1, 3,   1,  1,  IR_A,         32'h14);
        tbl[4]  = mk(32'h18, 32'h0,        1, 0, 1, 1, 4,   1,  1,  IR_A,         32'h14);
        tbl[5]  = mk(32'h18, IR_Z,         1, 0, 1, 1, 31,  0,  1,  IR_Z,         32'h18);
        tbl[6]  = mk(32'h1C, 32'h11111111, 1, 0, 1, 1, 31,  0,  1,  32'h11111111, 32'h1C);
        tbl[7]  = mk(32'h20, IR_A,         1, 0, 1, 0, 9,   0,  1,  IR_A,         32'h20);
        tbl[8]  = mk(32'h24, 32'h22222222, 0, 0, 0, 1, 3,   0,  0,  32'h22222222, 32'h24);
        tbl[9]  = mk(32'h28, IR_A,         1, 0, 1, 1, 18,  0,  1,  IR_A,         32'h28);
        tbl[10] = mk(32'h2C, 32'h33333333, 1, 1, 1, 1, 3,   0,  0,  NOP,          32'h2C);
        tbl[11] = mk(32'h30, 32'h44444444, 1, 0, 0, 0, 0,   0,  0,  NOP,          32'h30);
        tbl[12] = mk(32'h34, 32'h55555555, 1, 0, 0, 0, 0,   0,  1,  32'h55555555, 32'h34);
        tbl[13] = mk(32'h38, 32'h66666666, 1, 1, 0, 0, 0,   0,  0,  NOP,          32'h38);
        tbl[14] = mk(32'h3C, 32'h77777777, 1, 1, 0, 0, 0,   0,  0,  NOP,          32'h3C);
        tbl[15] = mk(32'h40, 32'h88888888, 1, 0, 0, 0, 0,   0,  0,  NOP,          32'h40);
        tbl[16] = mk(32'h44, 32'h99999999, 1, 0, 0, 0, 0,   0,  1,  32'h99999999, 32'h44);

        // Three-cycle squash window with a matching ID/EX load present throughout.
        seq5[0] = mk(32'h200, IR_A,  1, 0, 0, 0, 0,  0, 1, IR_A,  32'h200);
        seq5[1] = mk(32'h204, 32'h0, 1, 1, 1, 1, 3,  0, 0, NOP,   32'h204);
        seq5[2] = mk(32'h208, IR_A,  1, 0, 1, 1, 3,  0, 0, NOP,   32'h208);
        seq5[3] = mk(32'h20C, IR_A,  1, 0, 1, 1, 3,  0, 0, NOP,   32'h20C);
        seq5[4] = mk(32'h210, IR_A,  1, 0, 1, 1, 3,  0, 1, IR_A,  32'h210);
        seq5[5] = mk(32'h214, IR_A,  1, 0, 1, 1, 3,  1, 1, IR_A,  32'h210);
        seq5[6] = mk(32'h214, IR_A,  1, 0, 1, 1, 3,  1, 1, IR_A,  32'h210);
        seq5[7] = mk(32'h218, 32'h0, 1, 0, 0, 0, 0,  0, 1, 32'h0, 32'h218);

        // Reset state, release, then asynchronous mid-cycle reset.
        pc_in = 32'h100; npc_in = 32'h104; ir_in = 32'hABCD0000; v_in = 1'b1;
        @(posedge clk); #1;
        chk("reset pc", a_pc, 32'h0);
        chk("reset npc", a_npc, 32'h0);
        chk("reset ir", a_ir, NOP);
        chk("reset valid", 32'(a_v), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("release pc", a_pc, 32'h100);
        chk("release ir", a_ir, 32'hABCD0000);
        chk("release valid", 32'(a_v), 32'h1);
        #3 rst = 1'b0;
        #1;
        chk("async reset pc", a_pc, 32'h0);
        chk("async reset ir", a_ir, NOP);
        chk("async reset valid", 32'(a_v), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 17; i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        sel_b = 1'b1;
        for (int i = 0; i < 8; i++)
            apply(seq5[i], $sformatf("squash3_%0d", i));
        sel_b = 1'b0;

`ifdef IF_ID_PERF_CNT_EN
        rst = 1'b0;
        #1;
        chk("perf reset stall", a_stall, 32'h0);
        chk("perf reset flush", a_flush, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        apply(mk(32'h300, IR_A, 1, 0, 0, 0, 0, 0, 1, IR_A, 32'h300), "perf load");
        for (int i = 0; i < 5; i++)
            apply(mk(32'h304, IR_A, 1, 0, 1, 1, 3, 1, 1, IR_A, 32'h300), $sformatf("perf stall%0d", i));
        for (int i = 0; i < 2; i++)
            apply(mk(32'h308, 32'h0, 1, 1, 1, 1, 3, 0, 0, NOP, 32'h308), $sformatf("perf flush%0d", i));
        chk("perf stall_cnt", a_stall, 32'd5);
        chk("perf flush_cnt", a_flush, 32'd2);
        rst = 1'b0;
        #1;
        chk("perf clear stall", a_stall, 32'h0);
        chk("perf clear flush", a_flush, 32'h0);
        rst = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
